ide_pio_sequencer: RTL and testbench
====================================

# ide_pio_sequencer

Sequences ATA PIO register and data cycles for the IDE port on behalf of the 68000 bus. It sits between the bus-side decode (`ide_access`, `ide_enabled`) and the drive pins, replacing the fixed-latency strobe logic. It enforces per-mode setup, strobe and recovery times from a programmable PIO mode, honours IORDY, and generates DTACK.

## Interface
- `TIMEOUT_CYC`, default 255: CLK cycles allowed in IORDY wait before forced completion (used only with timeout feature).
- `CLK` in 1: bus clock (~7.09 MHz); all logic on rising edge.
- `RESET_n` in 1: **one clock; reset is synchronous and active-low**.
- `AS_n` in 1: 68000 address strobe.
- `UDS_n`, `LDS_n` in 1 each: data strobes.
- `RW` in 1: 1 = read, 0 = write.
- `ide_access` in 1: address decode hit for IDE space.
- `ide_enabled` in 1: IDE decode enabled (autoconfig complete).
- `IORDY` in 1: drive ready; low stretches the strobe.
- `mode_wr` in 1: one-cycle pulse, loads `mode_data`.
- `mode_data` in 3: requested PIO mode 0–4; 5–7 clamp to 4.
- `IOR_n`, `IOW_n` out 1 each: drive strobes, registered.
- `DTACK` out 1: cycle complete, registered, active-high.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky IORDY timeout flag.

## Operation
- **States:** IDLE, SETUP, STROBE, WAIT_RDY, ACK, RECOVER.
- **Mode timings** (cycles: setup S / pulse P / recovery R):
  - mode 0: 1/3/2
  - mode 1: 1/2/1
  - mode 2: 0/2/1
  - modes 3–4: 0/1/0
- **Start:** a request is `!AS_n && ide_access && ide_enabled && (!UDS_n || !LDS_n)`.
  - Sampled only in IDLE.
  - On a request, latch `RW` and the active mode's S/P/R, then go to SETUP. If S = 0, go directly to STROBE.
- **SETUP:** strobes high; counts S cycles, then STROBE.
- **STROBE:** `IOR_n` (read) or `IOW_n` (write) low; counts P cycles.
  - On the last cycle, if IORDY = 1, go to ACK; otherwise go to WAIT_RDY.
- **WAIT_RDY:** strobe stays low until IORDY is sampled 1, then ACK.
- **ACK:** strobes high, `DTACK` = 1; held until AS_n is sampled 1, then RECOVER.
- **RECOVER:** all outputs idle; counts R cycles, then IDLE. If R = 0, go directly to IDLE.
- **Abort:** if AS_n is sampled high in SETUP, STROBE or WAIT_RDY, strobes go high at that edge, DTACK stays 0, and the state goes to RECOVER.
- **Mode register:**
  - A `mode_wr` pulse updates a pending mode.
  - The active mode is copied from pending only in IDLE, so a running cycle never changes timing.
  - Reset value: mode 0.
- Deasserting `ide_enabled` mid-cycle has no effect; the cycle completes.
- **Reset** (sampled low at an edge): state IDLE, IOR_n = IOW_n = 1, DTACK = 0, busy = 0, timeout_err = 0, mode 0. Reset overrides all inputs, including mid-cycle.

## Timing
- Request sampled at edge E0:
  - strobe falls at edge E0+S.
  - strobe rises, and DTACK rises, at edge E0+S+P when IORDY = 1.
- Each cycle of IORDY low at the sampled edge extends both the strobe and DTACK by one cycle.
- DTACK falls at the first edge where AS_n is sampled high.
- The next request is accepted no earlier than R+1 edges after DTACK falls.
- IOR_n and IOW_n are never low simultaneously; both are high in every state except STROBE and WAIT_RDY.
- Write data hold is guaranteed by the bus: the strobe rises at least one cycle before DTACK can release the bus cycle.

## Configuration
- **`IDE_IORDY_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_RDY. After TIMEOUT_CYC cycles without IORDY, the state is forced to ACK (strobe high, DTACK = 1) and `timeout_err` is set.
  - `timeout_err` clears on `mode_wr` or reset.
- **Undefined:** WAIT_RDY waits indefinitely; `timeout_err` is constant 0 and there is no counter.

## Structure
- Package `ide_pkg` holds:
  - state enum `ide_state_t`
  - `ide_mode_t` (3-bit)
  - timing struct `ide_timing_t {setup, pulse, recover}`, 2 bits each
  - constant table `IDE_PIO_TIMING[0:4]`
- Sub-module `ide_timing_lut`: combinational mode → `ide_timing_t` with clamping; instantiated once.
- One shared 2-bit down-counter serves SETUP, STROBE and RECOVER. The timeout counter is separate and width is clog2(TIMEOUT_CYC+1).

## Test plan
- **Mode 0 read, IORDY = 1:** IOR_n low from E0+1 to E0+4; DTACK rises at E0+4; after AS_n high, busy clears 3 edges later.
- **Mode 4 write:** IOW_n low exactly one cycle starting at E0; DTACK at E0+1; IOR_n stays 1 throughout.
- **IORDY low for 5 cycles in mode 2:** strobe low for 2+5 cycles, DTACK delayed by 5.
- **mode_wr = 4 issued during a mode 0 cycle:** that cycle keeps 1/3/2; the next cycle uses 0/1/0. mode_data = 7 behaves as 4.
- **AS_n rises during STROBE:** strobe high at that edge, DTACK never asserts, RECOVER then IDLE.
- **With `IDE_IORDY_TIMEOUT_EN` and TIMEOUT_CYC = 8, IORDY held 0:** DTACK at 8 cycles into WAIT_RDY, timeout_err = 1 until mode_wr. Also: RESET_n low mid-WAIT_RDY gives all outputs idle at the next edge.

Source files
------------

// File: rtl/ide_pkg.sv
// Shared types and the PIO timing table for the IDE PIO sequencer.
package ide_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT_RDY,
    ACK,
    RECOVER
  } ide_state_t;

  typedef logic [2:0] ide_mode_t;

  typedef struct packed {
    logic [1:0] setup;
    logic [1:0] pulse;
    logic [1:0] recover;
  } ide_timing_t;

  localparam ide_mode_t IDE_MAX_MODE = 3'd4;

  // Cycle counts at ~7.09 MHz; modes 3 and 4 are both limited by one bus clock.
  localparam ide_timing_t IDE_PIO_TIMING [0:4] = '{
    '{setup: 2'd1, pulse: 2'd3, recover: 2'd2},
    '{setup: 2'd1, pulse: 2'd2, recover: 2'd1},
    '{setup: 2'd0, pulse: 2'd2, recover: 2'd1},
    '{setup: 2'd0, pulse: 2'd1, recover: 2'd0},
    '{setup: 2'd0, pulse: 2'd1, recover: 2'd0}
  };

endpackage

// File: rtl/ide_timing_lut.sv
// Combinational PIO mode to setup/pulse/recovery lookup; modes above 4 clamp to 4.
module ide_timing_lut
  import ide_pkg::*;
(
  input  ide_mode_t   mode,
  output ide_timing_t timing
);

  ide_mode_t mode_clamped;

  always_comb begin
    mode_clamped = (mode > IDE_MAX_MODE) ? IDE_MAX_MODE : mode;
    timing       = IDE_PIO_TIMING[mode_clamped];
  end

endmodule

// File: rtl/ide_pio_sequencer.sv
// ATA PIO strobe/DTACK sequencer for the 68000 IDE port.
// Optional IORDY timeout is built when IDE_IORDY_TIMEOUT_EN is defined.
module ide_pio_sequencer
  import ide_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ide_access,
  input  logic       ide_enabled,
  input  logic       IORDY,
  input  logic       mode_wr,
  input  logic [2:0] mode_data,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       DTACK,
  output logic       busy,
  output logic       timeout_err
);

  ide_state_t  state, state_d, rec_state;
  logic [1:0]  cnt, cnt_d, rec_cnt;
  ide_mode_t   mode_pend;
  ide_timing_t lut_t, cur_t, t_use;
  logic        rw_q, rw_use;
  logic        req, strobe_on;
  logic        ior_d, iow_d, dtack_d;

`ifdef IDE_IORDY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, tmo_fire, tmo_err_q;
`endif

  ide_timing_lut u_lut (
    .mode   (mode_pend),
    .timing (lut_t)
  );

  assign req = !AS_n && ide_access && ide_enabled && (!UDS_n || !LDS_n);

  // While idle the pending mode is live; once a cycle starts its timing is frozen.
  assign t_use  = (state == IDLE) ? lut_t : cur_t;
  assign rw_use = (state == IDLE) ? RW : rw_q;

  // NOTE: the reset is sampled on the clock edge, so every register (including
  // the timing/mode holding registers) sits inside the same synchronous branch.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      mode_pend <= 3'd0;
      cur_t     <= IDE_PIO_TIMING[0];
      rw_q      <= 1'b1;
      IOR_n     <= 1'b1;
      IOW_n     <= 1'b1;
      DTACK     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_d;
      cnt   <= cnt_d;
      cur_t <= t_use;
      rw_q  <= rw_use;
      IOR_n <= ior_d;
      IOW_n <= iow_d;
      DTACK <= dtack_d;
      if (mode_wr) mode_pend <= mode_data;
    end
  end

`ifdef IDE_IORDY_TIMEOUT_EN
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign tmo_fire = (state == WAIT_RDY) && !AS_n && !IORDY && tmo_hit;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT_RDY) ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire)     tmo_err_q <= 1'b1;
      else if (mode_wr) tmo_err_q <= 1'b0;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_d   = state;
    cnt_d     = cnt;
    rec_state = (t_use.recover == 2'd0) ? IDLE : RECOVER;
    rec_cnt   = t_use.recover - 2'd1;
    case (state)
      IDLE: if (req) begin
        if (t_use.setup == 2'd0) begin
          state_d = STROBE;
          cnt_d   = t_use.pulse - 2'd1;
        end else begin
          state_d = SETUP;
          cnt_d   = t_use.setup - 2'd1;
        end
      end
      SETUP: begin
        if (AS_n) begin
          state_d = rec_state;
          cnt_d   = rec_cnt;
        end else if (cnt == 2'd0) begin
          state_d = STROBE;
          cnt_d   = t_use.pulse - 2'd1;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      STROBE: begin
        if (AS_n) begin
          state_d = rec_state;
          cnt_d   = rec_cnt;
        end else if (cnt == 2'd0) begin
          state_d = IORDY ? ACK : WAIT_RDY;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      WAIT_RDY: begin
        if (AS_n) begin
          state_d = rec_state;
          cnt_d   = rec_cnt;
        end else if (IORDY) begin
          state_d = ACK;
        end
`ifdef IDE_IORDY_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ACK;
        end
`endif
      end
      ACK: if (AS_n) begin
        state_d = rec_state;
        cnt_d   = rec_cnt;
      end
      RECOVER: begin
        if (cnt == 2'd0) state_d = IDLE;
        else             cnt_d   = cnt - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge.
  always_comb begin
    strobe_on = (state_d == STROBE) || (state_d == WAIT_RDY);
    ior_d     = !(strobe_on && rw_use);
    iow_d     = !(strobe_on && !rw_use);
    dtack_d   = (state_d == ACK);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Self-checking bench for ide_pio_sequencer: window-based timing model plus literal pins.
module tb_ide_pio_sequencer;

  localparam int     TIMEOUT_CYC = 8;
  localparam longint BIG         = 64'd1_000_000_000;

  logic       CLK = 1'b0;
  logic       RESET_n, AS_n, UDS_n, LDS_n, RW, ide_access, ide_enabled, IORDY, mode_wr;
  logic [2:0] mode_data;
  logic       IOR_n, IOW_n, DTACK, busy, timeout_err;

  ide_pio_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .AS_n        (AS_n),
    .UDS_n       (UDS_n),
    .LDS_n       (LDS_n),
    .RW          (RW),
    .ide_access  (ide_access),
    .ide_enabled (ide_enabled),
    .IORDY       (IORDY),
    .mode_wr     (mode_wr),
    .mode_data   (mode_data),
    .IOR_n       (IOR_n),
    .IOW_n       (IOW_n),
    .DTACK       (DTACK),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Setup / pulse / recovery cycles per mode.
  int TS [5] = '{1, 1, 0, 0, 0};
  int TP [5] = '{3, 2, 2, 1, 1};
  int TR [5] = '{2, 1, 1, 0, 0};

  // Model of the current transaction, in edge numbers.
  longint     t_e0 = BIG, t_as = BIG, err_from = BIG, err_until = BIG;
  int         t_s = 0, t_p = 0, t_k = 0, t_r = 0;
  logic       t_abort = 1'b0, t_rw = 1'b1;
  logic [2:0] pend = 3'd0;
  bit         cmp_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic h_ior [64];
  logic h_iow [64];
  logic h_dt  [64];
  logic h_bsy [64];
  logic h_err [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge CLK);
    #1;
  endtask

  // Per-cycle compare against the window model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      longint t_end;
      logic   in_s, e_dt, e_busy, e_err;
      t_end  = t_abort ? t_as : t_e0 + t_s + t_p + t_k;
      in_s   = (cyc >= t_e0 + t_s) && (cyc < t_end);
      e_dt   = !t_abort && (cyc >= t_end) && (cyc < t_as);
      e_busy = (cyc >= t_e0) && (cyc < t_as + t_r);
      e_err  = (cyc >= err_from) && (cyc < err_until);
      check($sformatf("cyc%0d_IOR_n", cyc), IOR_n, !(in_s && t_rw));
      check($sformatf("cyc%0d_IOW_n", cyc), IOW_n, !(in_s && !t_rw));
      check($sformatf("cyc%0d_DTACK", cyc), DTACK, e_dt);
      check($sformatf("cyc%0d_busy", cyc), busy, e_busy);
      check($sformatf("cyc%0d_timeout_err", cyc), timeout_err, e_err);
    end
  end

  task automatic mode_w(input logic [2:0] d);
    longint n;
    n         = cyc + 1;
    mode_wr   = 1'b1;
    mode_data = d;
    pend      = d;
    if (err_from < n && err_until > n) err_until = n;
    wait_edge();
    mode_wr = 1'b0;
    wait_edge();
  endtask

  // One bus cycle; offsets (abort_at, reset_at, mw_at) count edges from the request edge.
  task automatic xfer(input logic rw, input int k, input int abort_at, input int reset_at,
                      input int mw_at, input logic [2:0] mw_data);
    int     m, s, p, r, kk;
    longint e0, w, as_edge, n;
    bit     as_done;
    m  = (pend > 3'd4) ? 4 : int'(pend);
    s  = TS[m];
    p  = TP[m];
    r  = TR[m];
    kk = k;
    e0 = cyc + 1;
    w  = e0 + s + p;
`ifdef IDE_IORDY_TIMEOUT_EN
    if (k > TIMEOUT_CYC) begin
      kk        = TIMEOUT_CYC;
      err_from  = w + TIMEOUT_CYC;
      err_until = BIG;
    end
`endif
    as_edge = w + kk + 1;
    t_e0 = e0; t_s = s; t_p = p; t_k = kk; t_r = r;
    t_as = BIG; t_abort = 1'b0; t_rw = rw;
    AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = rw;
    as_done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      n           = e0 + i;
      RESET_n     = 1'b1;
      mode_wr     = 1'b0;
      ide_enabled = (i == 0);
      IORDY       = !(n >= w && n < w + k);
      if (i == mw_at) begin
        mode_wr   = 1'b1;
        mode_data = mw_data;
        pend      = mw_data;
        if (err_from < n && err_until > n) err_until = n;
      end
      if (!as_done) begin
        if (i == reset_at) begin
          RESET_n = 1'b0;
          pend    = 3'd0;
          t_r     = 0;
          if (err_until > n) err_until = n;
          as_done = 1'b1;
        end else if (i == abort_at || n == as_edge) begin
          as_done = 1'b1;
        end
        if (as_done) begin
          AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
          t_as    = n;
          t_abort = (i == reset_at) || (i == abort_at);
        end
      end
      wait_edge();
      h_ior[i] = IOR_n;
      h_iow[i] = IOW_n;
      h_dt[i]  = DTACK;
      h_bsy[i] = busy;
      h_err[i] = timeout_err;
      if (as_done && n >= t_as + t_r + 1) break;
    end
    RESET_n = 1'b1; mode_wr = 1'b0; ide_enabled = 1'b1; IORDY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic any_dt;
    RESET_n = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    ide_access = 1'b1; ide_enabled = 1'b1; IORDY = 1'b1; mode_wr = 1'b0; mode_data = 3'd0;
    repeat (3) wait_edge();
    RESET_n = 1'b1;
    cmp_en  = 1'b1;
    check("rst_IOR_n", IOR_n, 1'b1);
    check("rst_IOW_n", IOW_n, 1'b1);
    check("rst_DTACK", DTACK, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    wait_edge();

    // Mode 0 read, IORDY high.
    xfer(1'b1, 0, -1, -1, -1, 3'd0);
    check("m0_ior_e0", h_ior[0], 1'b1);
    check("m0_ior_e1", h_ior[1], 1'b0);
    check("m0_ior_e3", h_ior[3], 1'b0);
    check("m0_ior_e4", h_ior[4], 1'b1);
    check("m0_dtack_e3", h_dt[3], 1'b0);
    check("m0_dtack_e4", h_dt[4], 1'b1);
    check("m0_busy_e6", h_bsy[6], 1'b1);
    check("m0_busy_e7", h_bsy[7], 1'b0);

    // Mode 4 write.
    mode_w(3'd4);
    xfer(1'b0, 0, -1, -1, -1, 3'd0);
    check("m4w_iow_e0", h_iow[0], 1'b0);
    check("m4w_iow_e1", h_iow[1], 1'b1);
    check("m4w_ior_e0", h_ior[0], 1'b1);
    check("m4w_dtack_e0", h_dt[0], 1'b0);
    check("m4w_dtack_e1", h_dt[1], 1'b1);

    // Mode 2 read with IORDY low for 5 sampled edges.
    mode_w(3'd2);
    xfer(1'b1, 5, -1, -1, -1, 3'd0);
    check("m2rdy_ior_e6", h_ior[6], 1'b0);
    check("m2rdy_ior_e7", h_ior[7], 1'b1);
    check("m2rdy_dtack_e6", h_dt[6], 1'b0);
    check("m2rdy_dtack_e7", h_dt[7], 1'b1);

    // Mode write during a running mode 0 cycle takes effect only on the next cycle.
    mode_w(3'd0);
    xfer(1'b1, 0, -1, -1, 2, 3'd4);
    check("mwmid_ior_e3", h_ior[3], 1'b0);
    check("mwmid_ior_e4", h_ior[4], 1'b1);
    check("mwmid_dtack_e4", h_dt[4], 1'b1);
    xfer(1'b1, 0, -1, -1, -1, 3'd0);
    check("mwnext_ior_e0", h_ior[0], 1'b0);
    check("mwnext_dtack_e1", h_dt[1], 1'b1);

    // Mode 7 clamps to mode 4.
    mode_w(3'd0);
    mode_w(3'd7);
    xfer(1'b0, 0, -1, -1, -1, 3'd0);
    check("m7_iow_e0", h_iow[0], 1'b0);
    check("m7_iow_e1", h_iow[1], 1'b1);
    check("m7_dtack_e1", h_dt[1], 1'b1);

    // AS_n rises during STROBE in mode 0.
    mode_w(3'd0);
    xfer(1'b1, 0, 2, -1, -1, 3'd0);
    any_dt = 1'b0;
    for (int i = 0; i < 6; i++) any_dt |= h_dt[i];
    check("abort_ior_e1", h_ior[1], 1'b0);
    check("abort_ior_e2", h_ior[2], 1'b1);
    check("abort_no_dtack", any_dt, 1'b0);
    check("abort_busy_e3", h_bsy[3], 1'b1);
    check("abort_busy_e4", h_bsy[4], 1'b0);

`ifdef IDE_IORDY_TIMEOUT_EN
    // IORDY stuck low: forced completion after TIMEOUT_CYC cycles in WAIT_RDY.
    mode_w(3'd4);
    xfer(1'b1, 20, -1, -1, -1, 3'd0);
    check("tmo_ior_e8", h_ior[8], 1'b0);
    check("tmo_ior_e9", h_ior[9], 1'b1);
    check("tmo_dtack_e8", h_dt[8], 1'b0);
    check("tmo_dtack_e9", h_dt[9], 1'b1);
    check("tmo_err_e8", h_err[8], 1'b0);
    check("tmo_err_e9", h_err[9], 1'b1);
    check("tmo_err_sticky", timeout_err, 1'b1);
    mode_w(3'd4);
    check("tmo_err_cleared", timeout_err, 1'b0);
`else
    check("tmo_err_const0", timeout_err, 1'b0);
`endif

    // Reset in the middle of WAIT_RDY, then the mode is back to 0.
    mode_w(3'd4);
    xfer(1'b1, 10, -1, 3, -1, 3'd0);
    check("rstmid_ior_e2", h_ior[2], 1'b0);
    check("rstmid_ior_e3", h_ior[3], 1'b1);
    check("rstmid_busy_e3", h_bsy[3], 1'b0);
    check("rstmid_dtack_e3", h_dt[3], 1'b0);
    xfer(1'b1, 0, -1, -1, -1, 3'd0);
    check("postrst_ior_e1", h_ior[1], 1'b0);
    check("postrst_dtack_e3", h_dt[3], 1'b0);
    check("postrst_dtack_e4", h_dt[4], 1'b1);

    wait_edge();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
